refresh_scheduler: RTL and testbench

REFRESH_SCHEDULER -- requirements
Module: refresh_scheduler

---
 rtl/refresh_scheduler.sv | 64 ++++++
 tb/tb_refresh_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/refresh_scheduler.sv
// refresh_scheduler: tREFI tick generator with postponed-refresh credit tracking.
// Optional pull-in of refreshes while idle is enabled by defining REFRESH_PULLIN_EN.
module refresh_scheduler #(
  parameter int C_TREFI_WIDTH = 16,
  parameter int C_MAX_POSTPONE = 8
) (
  input  logic                     core_clk,
  input  logic                     core_srst,
  input  logic                     enable,
  input  logic [C_TREFI_WIDTH-1:0] trefi,
  input  logic                     ref_ack,
  input  logic                     idle,
  output logic                     ref_req,
  output logic                     ref_urgent,
  output logic [3:0]               pending,
  output logic                     overflow
);
  typedef enum logic {DIS, RUN} state_t;
  localparam logic [3:0] MAX = 4'(C_MAX_POSTPONE);
  localparam logic [3:0] MAX_M1 = 4'(C_MAX_POSTPONE - 1);
  state_t state, state_n;
  logic [C_TREFI_WIDTH-1:0] timer, reload;
  logic run, tick, acc, pull_req, pull_use;
  always_comb begin
    state_n = enable ? RUN : DIS;
    run = state == RUN;
    reload = trefi == '0 ? '0 : trefi - C_TREFI_WIDTH'(1);
    tick = run && timer == '0 && trefi != '0;
    ref_req = run && (pending != '0 || pull_req);
    ref_urgent = run && pending >= MAX_M1;
    acc = ref_req && ref_ack;
  end
`ifdef REFRESH_PULLIN_EN
  logic [3:0] pullin;
  assign pull_req = pending == '0 && idle && pullin < MAX;
  assign pull_use = pullin != '0;
  // A tick repays an earlier pull-in before it creates a new postponed credit.
  always_ff @(posedge core_clk) begin
    if (core_srst) pullin <= '0;
    else if (tick && !acc && pullin != '0) pullin <= pullin - 4'd1;
    else if (acc && !tick && pending == '0) pullin <= pullin + 4'd1;
  end
`else
  logic unused_idle;
  assign unused_idle = idle;
  assign pull_req = 1'b0;
  assign pull_use = 1'b0;
`endif
  always_ff @(posedge core_clk) begin
    if (core_srst) begin
      state <= DIS;
      timer <= '0;
      pending <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      timer <= (!run || timer == '0) ? reload : timer - C_TREFI_WIDTH'(1);
      if (tick && !acc && !pull_use) begin
        if (pending == MAX) overflow <= 1'b1;
        else pending <= pending + 4'd1;
      end else if (acc && !tick && pending != '0) pending <= pending - 4'd1;
    end
  end
endmodule

// File: tb/tb_refresh_scheduler.sv
// tb_refresh_scheduler: random and directed stimulus against a cycle-count reference model.
module tb_refresh_scheduler;
  localparam int MAX = 8;
`ifdef REFRESH_PULLIN_EN
  localparam bit PULL = 1'b1;
`else
  localparam bit PULL = 1'b0;
`endif
  logic clk = 0, rst = 1, en = 0, ack = 0, idle = 0;
  logic [15:0] trefi = 16'd100;
  logic ref_req, ref_urgent, overflow;
  logic [3:0] pending;
  int total = 0, bad = 0;
  logic [6:0] exp_q[$];
  bit m_run = 0, m_ovf = 0;
  int m_n = 0, m_pend = 0, m_pull = 0;

  refresh_scheduler dut (
    .core_clk(clk), .core_srst(rst), .enable(en), .trefi(trefi), .ref_ack(ack),
    .idle(idle), .ref_req(ref_req), .ref_urgent(ref_urgent), .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic bit m_req(input bit i);
    return m_run && (m_pend != 0 || (PULL && i && m_pull < MAX));
  endfunction

  // refresh interval elapses at the end of every trefi-th cycle spent in RUN
  function automatic bit tick_next();
    return m_run && trefi != 0 && ((m_n + 1) % int'(trefi) == 0);
  endfunction

  function automatic logic [6:0] expect_now(input bit i);
    return {m_req(i), m_run && m_pend >= MAX - 1, 4'(m_pend), m_ovf};
  endfunction

  task automatic model(input bit r, input bit e, input bit a, input bit i);
    bit tk, ac;
    if (r) begin
      m_run = 0; m_n = 0; m_pend = 0; m_pull = 0; m_ovf = 0;
    end else begin
      tk = tick_next();
      ac = m_req(i) && a;
      if (tk && !ac) begin
        if (m_pull > 0) m_pull--;
        else if (m_pend == MAX) m_ovf = 1;
        else m_pend++;
      end else if (ac && !tk) begin
        if (m_pend > 0) m_pend--;
        else m_pull++;
      end
      m_n = (m_run && e) ? m_n + 1 : 0;
      m_run = e;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit a, input bit i);
    rst = r; en = e; ack = a; idle = i;
    exp_q.push_back(expect_now(i));
    @(posedge clk); #1;
    model(r, e, a, i);
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [6:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({ref_req, ref_urgent, pending, overflow} !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got req/urg/pend/ovf=%b/%b/%0d/%b want=%b/%b/%0d/%b",
                 $time, ref_req, ref_urgent, pending, overflow, e[6], e[5], e[4:1], e[0]);
      end
    end
  end

  initial begin
    int guard;
    bit e, r;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 0, 0);
    chk("reset_pending", pending, 0);
    chk("reset_req", ref_req, 0);
    // long run without acks: credits saturate then overflow sticks
    trefi = 16'd100;
    repeat (950) step(0, 1, 0, 0);
    chk("sat_pending", pending, 8);
    chk("sat_overflow", overflow, 1);
    chk("sat_urgent", ref_urgent, 1);
    step(1, 0, 0, 0);
    chk("ovf_cleared", overflow, 0);
    // prompt acks keep pending toggling between 0 and 1
    trefi = 16'd10;
    step(0, 0, 0, 0);
    repeat (1000) step(0, 1, m_req(0), 0);
    chk("ack_overflow", overflow, 0);
    chk("ack_pending_max", (m_pend <= 1) ? 1 : 0, 1);
    // ack coinciding with tick at full credit keeps pending and no overflow
    guard = 0;
    while (m_pend < MAX && guard < 200) begin step(0, 1, 0, 0); guard++; end
    chk("reach_full", m_pend, MAX);
    guard = 0;
    while (!tick_next() && guard < 50) begin step(0, 1, 0, 0); guard++; end
    step(0, 1, 1, 0);
    chk("coinc_pending", pending, 8);
    chk("coinc_overflow", overflow, 0);
    // reset mid-operation clears credits
    step(1, 0, 0, 0);
    guard = 0;
    while (m_pend < 3 && guard < 100) begin step(0, 1, 0, 0); guard++; end
    step(1, 1, 0, 0);
    chk("rst_pending", pending, 0);
    chk("rst_req", ref_req, 0);
    chk("rst_overflow", overflow, 0);
    repeat (25) step(0, 1, 0, 0);
    // stray acks and a halted timer
    step(1, 0, 0, 0);
    trefi = 16'd0;
    repeat (5) step(0, 0, 1, 0);
    repeat (60) step(0, 1, 1, 0);
    chk("halt_pending", pending, 0);
`ifdef REFRESH_PULLIN_EN
    step(1, 0, 0, 0);
    trefi = 16'd50;
    step(0, 0, 0, 1);
    repeat (20) step(0, 1, m_req(1), 1);
    chk("pullin_req_low", ref_req, 0);
    repeat (400) step(0, 1, 0, 0);
    chk("pullin_drained_pend", pending, 0);
`endif
    // randomized mix with occasional resets and enable toggles
    step(1, 0, 0, 0);
    e = 0;
    repeat (3000) begin
      r = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 49) == 0) e = !e;
      if (!e && !m_run && $urandom_range(0, 3) == 0)
        case ($urandom_range(0, 5))
          0: trefi = 16'd0;
          1: trefi = 16'd1;
          2: trefi = 16'd2;
          3: trefi = 16'd3;
          4: trefi = 16'd5;
          default: trefi = 16'd10;
        endcase
      step(r, e, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
